// File: rtl/cpu_pkg.sv
// Shared constants and types for the ARM-subset pipeline.
//   XLEN      : address / instruction width
//   RESET_PC  : default PC loaded on reset
//   PC_INC    : sequential PC increment
//   fetch_state_t : instruction-fetch FSM states
package cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address, stable while imem_req=1
//   imem_ack   : transfer completes when imem_req && imem_ack
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch stage, slave = instruction memory.
interface if_stage_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst  : clock, asynchronous active-low reset
//   load_i    : capture pc_i/instr_i and mark valid
//   freeze_i  : hold contents (blocks load_i)
//   flush_i   : clear the valid bit; wins over freeze and load
//   pc_i, instr_i          : incoming fetch result
//   pc_o, instr_o, valid_o : registered IF/ID contents
module if_id_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            freeze_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o    <= '0;
      instr_o <= '0;
      valid_o <= 1'b0;
    end else if (flush_i) begin
      // A bubble only needs the valid bit cleared; payload is don't-care.
      valid_o <= 1'b0;
    end else if (load_i && !freeze_i) begin
      pc_o    <= pc_i;
      instr_o <= instr_i;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one fetch per handshake to a
// variable-latency instruction memory and fills the IF/ID register.
//   clk, rst       : clock, asynchronous active-low reset
//   Hazard         : freeze from the hazard unit
//   Branch_Taken   : redirect from EX (flushes IF/ID)
//   Branch_Addr    : redirect target
//   imem           : instruction-memory bus (master side)
//   PC             : IF/ID fetched address + 4
//   Instruction    : IF/ID instruction word
//   IF_Valid       : IF/ID holds a real instruction
//
// state | meaning
// IDLE  | just out of reset, no request
// REQ   | request outstanding at pc_q
// HOLD  | fetched word parked in buf while Hazard is high
// DROP  | finishing an abandoned request at drop_addr_q after a branch
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Hazard,
  input  logic              Branch_Taken,
  input  logic [XLEN-1:0]   Branch_Addr,
  if_stage_if.master        imem,
  output logic [XLEN-1:0]   PC,
  output logic [XLEN-1:0]   Instruction,
  output logic              IF_Valid
);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] buf_pc_q;
  logic [XLEN-1:0] buf_instr_q;
  logic [XLEN-1:0] drop_addr_q;

  logic [XLEN-1:0] pc_plus4;
  logic            xfer;
  logic            idr_load;
  logic            idr_flush;
  logic [XLEN-1:0] idr_pc_d;
  logic [XLEN-1:0] idr_instr_d;

  // Bus outputs decode registered state only; the memory sees no path
  // from its own ack back to req/addr.
  assign imem.imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

  assign pc_plus4 = pc_q + XLEN'(PC_INC);
  assign xfer     = imem.imem_req && imem.imem_ack;

  always_comb begin
    idr_load    = 1'b0;
    idr_flush   = 1'b0;
    idr_pc_d    = pc_plus4;
    idr_instr_d = imem.imem_rdata;
    if (Branch_Taken) begin
      idr_flush = 1'b1;
    end else begin
      unique case (state_q)
        REQ: begin
          if (xfer && !Hazard)       idr_load  = 1'b1;
          else if (!xfer && !Hazard) idr_flush = 1'b1;
        end
        HOLD: begin
          if (!Hazard) begin
            idr_load    = 1'b1;
            idr_pc_d    = buf_pc_q;
            idr_instr_d = buf_instr_q;
          end
        end
        DROP: begin
          if (xfer) idr_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      drop_addr_q <= '0;
    end else if (Branch_Taken) begin
      pc_q <= Branch_Addr;
      // A request that is still pending must be completed, not withdrawn.
      if (state_q == REQ && !xfer) begin
        drop_addr_q <= pc_q;
        state_q     <= DROP;
      end else if (state_q == DROP) begin
        state_q <= DROP;
      end else begin
        state_q <= REQ;
      end
    end else begin
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (xfer) begin
            pc_q <= pc_plus4;
            if (Hazard) begin
              buf_pc_q    <= pc_plus4;
              buf_instr_q <= imem.imem_rdata;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!Hazard) state_q <= REQ;
        end
        DROP: begin
          if (xfer) state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (idr_load),
    .freeze_i (Hazard),
    .flush_i  (idr_flush),
    .pc_i     (idr_pc_d),
    .instr_i  (idr_instr_d),
    .pc_o     (PC),
    .instr_o  (Instruction),
    .valid_o  (IF_Valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The memory returns addr ^ 32'hA5A5_A5A5.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        Hazard;
  logic        Branch_Taken;
  logic [31:0] Branch_Addr;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        IF_Valid;

  int checks = 0;
  int errors = 0;

  if_stage_if #(.XLEN(32)) bus ();

  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_A5A5;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .Hazard       (Hazard),
    .Branch_Taken (Branch_Taken),
    .Branch_Addr  (Branch_Addr),
    .imem         (bus.master),
    .PC           (PC),
    .Instruction  (Instruction),
    .IF_Valid     (IF_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] pc, input logic [31:0] ins, input logic vld);
    chk({tag, ".req"},   {31'd0, bus.imem_req}, {31'd0, req});
    chk({tag, ".addr"},  bus.imem_addr, addr);
    chk({tag, ".pc"},    PC, pc);
    chk({tag, ".instr"}, Instruction, ins);
    chk({tag, ".valid"}, {31'd0, IF_Valid}, {31'd0, vld});
  endtask

  initial begin
    rst          = 1'b0;
    Hazard       = 1'b0;
    Branch_Taken = 1'b0;
    Branch_Addr  = 32'h0;
    bus.imem_ack = 1'b0;

    step(); step();
    chk_out("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Steady stream with ack tied high.
    rst = 1'b1; bus.imem_ack = 1'b1;
    step();
    chk_out("first_req", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_out("stream0", 1'b1, 32'h4, 32'h4, 32'hA5A5A5A5, 1'b1);
    step();
    chk_out("stream1", 1'b1, 32'h8, 32'h8, 32'hA5A5A5A1, 1'b1);
    step();
    chk_out("stream2", 1'b1, 32'hC, 32'hC, 32'hA5A5A5AD, 1'b1);

    // Slow memory: 0xC acked in the third cycle of its request.
    bus.imem_ack = 1'b0;
    step();
    chk_out("slow_w1", 1'b1, 32'hC, 32'hC, 32'hA5A5A5AD, 1'b0);
    step();
    chk_out("slow_w2", 1'b1, 32'hC, 32'hC, 32'hA5A5A5AD, 1'b0);
    bus.imem_ack = 1'b1;
    step();
    chk_out("slow_done", 1'b1, 32'h10, 32'h10, 32'hA5A5A5A9, 1'b1);

    // Freeze across the transfer at 0x10.
    Hazard = 1'b1;
    step();
    chk_out("hold1", 1'b0, 32'h14, 32'h10, 32'hA5A5A5A9, 1'b1);
    bus.imem_ack = 1'b0;
    step();
    chk_out("hold2", 1'b0, 32'h14, 32'h10, 32'hA5A5A5A9, 1'b1);
    Hazard = 1'b0;
    step();
    chk_out("unhold", 1'b1, 32'h14, 32'h14, 32'hA5A5A5B5, 1'b1);
    bus.imem_ack = 1'b1;
    step();
    chk_out("no_dup", 1'b1, 32'h18, 32'h18, 32'hA5A5A5B1, 1'b1);
    step();
    step();
    chk_out("at_0x20", 1'b1, 32'h20, 32'h20, 32'hA5A5A5B9, 1'b1);

    // Branch while the request at 0x20 is outstanding.
    bus.imem_ack = 1'b0;
    step();
    chk_out("pend_20", 1'b1, 32'h20, 32'h20, 32'hA5A5A5B9, 1'b0);
    Branch_Taken = 1'b1; Branch_Addr = 32'h100;
    step();
    chk_out("drop1", 1'b1, 32'h20, 32'h20, 32'hA5A5A5B9, 1'b0);
    Branch_Taken = 1'b0;
    step();
    chk_out("drop2", 1'b1, 32'h20, 32'h20, 32'hA5A5A5B9, 1'b0);
    bus.imem_ack = 1'b1;
    step();
    chk_out("drop_ack", 1'b1, 32'h100, 32'h20, 32'hA5A5A5B9, 1'b0);
    step();
    chk_out("tgt_fetch", 1'b1, 32'h104, 32'h104, 32'hA5A5A4A5, 1'b1);

    // Branch, freeze and ack in the same cycle.
    Branch_Taken = 1'b1; Hazard = 1'b1; Branch_Addr = 32'h100;
    step();
    chk_out("br_vs_hz", 1'b1, 32'h100, 32'h104, 32'hA5A5A4A5, 1'b0);
    Branch_Taken = 1'b0; Hazard = 1'b0;
    step();
    chk_out("br_vs_hz_next", 1'b1, 32'h104, 32'h104, 32'hA5A5A4A5, 1'b1);

    // PC wrap at the top of the address space.
    Branch_Taken = 1'b1; Branch_Addr = 32'hFFFF_FFFC;
    step();
    chk_out("wrap_br", 1'b1, 32'hFFFF_FFFC, 32'h104, 32'hA5A5A4A5, 1'b0);
    Branch_Taken = 1'b0;
    step();
    chk_out("wrap", 1'b1, 32'h0, 32'h0, 32'h5A5A5A59, 1'b1);
    step();
    chk_out("post_wrap", 1'b1, 32'h4, 32'h4, 32'hA5A5A5A5, 1'b1);

    // Asynchronous reset while a request is waiting.
    bus.imem_ack = 1'b0;
    step();
    chk_out("wait4", 1'b1, 32'h4, 32'h4, 32'hA5A5A5A5, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    rst = 1'b1; bus.imem_ack = 1'b1;
    step();
    chk_out("rerun_req", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_out("rerun_first", 1'b1, 32'h4, 32'h4, 32'hA5A5A5A5, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage ARM-subset pipeline. It holds the PC and fetches one instruction per handshake from a variable-latency instruction memory. It drives the IF/ID pipeline register consumed by the ID stage. It obeys the `Hazard` freeze from the hazard unit and the `Branch_Taken` redirect/flush from EX.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `XLEN`, default 32: address and instruction width.

- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Hazard`  in  1  freeze: IF/ID and PC must not advance.
- `Branch_Taken`  in  1  redirect request from EX; flushes IF/ID.
- `Branch_Addr`  in  XLEN  redirect target, sampled when `Branch_Taken`=1.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  XLEN  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  transfer completes in any cycle with `imem_req`&&`imem_ack`.
- `imem_rdata`  in  XLEN  instruction, valid with `imem_ack`.
- `PC`  out  XLEN  IF/ID: fetched address + 4.
- `Instruction`  out  XLEN  IF/ID instruction word.
- `IF_Valid`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- **State `IDLE`:** `imem_req`=0. Entered only by reset. Goes to `REQ` unconditionally on the next edge.
- **State `REQ`:** `imem_req`=1, `imem_addr`=pc_q.
  - Transfer with `Hazard`=0: IF/ID ← {pc_q+4, `imem_rdata`, 1}; pc_q ← pc_q+4; stay in `REQ`.
  - Transfer with `Hazard`=1: buf ← {pc_q+4, `imem_rdata`}; pc_q ← pc_q+4; go to `HOLD`. IF/ID is unchanged.
  - No transfer, `Hazard`=0: `IF_Valid` ← 0 (bubble). No transfer, `Hazard`=1: IF/ID is unchanged.
- **State `HOLD`:** `imem_req`=0. While `Hazard`=1, everything holds. When `Hazard`=0: IF/ID ← {buf, 1}, then go to `REQ`.
- **State `DROP`:** `imem_req`=1, `imem_addr`=drop_addr_q (the address of the abandoned request). On ack the data is discarded, `IF_Valid`=0, and the state goes to `REQ`. Without ack, the state stays in `DROP`.
- **`Branch_Taken`=1 has highest priority in every state.** `IF_Valid` ← 0 and pc_q ← `Branch_Addr`; any buf content is discarded.
  - From `REQ` with no ack this cycle: drop_addr_q ← pc_q, go to `DROP`. A pending request is never withdrawn or re-addressed.
  - From `REQ` with ack this cycle: discard the data, go to `REQ`.
  - From `HOLD`: go to `REQ`.
  - From `DROP`: pc_q is overwritten, stay in `DROP`.
  - `Hazard` is ignored in a cycle where `Branch_Taken`=1.
- **Arithmetic:** pc_q+4 is modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0x0000_0000. `Branch_Addr` is used as given, with no alignment check.

## Timing
- **Reset values:** state=`IDLE`, pc_q=`RESET_PC`, `imem_req`=0, `PC`=0, `Instruction`=0, `IF_Valid`=0, buf=0, drop_addr_q=0.
- **Reset mid-transaction:** any outstanding request is abandoned. The memory must tolerate this.
- **First request:** `imem_req` rises in the first cycle after reset deasserts, from `IDLE` to `REQ`.
- **Latency:** the IF/ID outputs update on the edge that completes the transfer (1 edge after ack is sampled). Peak throughput is 1 instruction per cycle with `imem_ack` tied high.
- `imem_req` and `imem_addr` are registered-state decodes with no combinational path from `imem_ack`.
- **Redirect latency:** the first request to `Branch_Addr` is issued 1 cycle after `Branch_Taken`. If a request was outstanding, it is issued 1 cycle after the `DROP` ack.
- **Freeze guarantee:** `Hazard` never causes an instruction to be lost or duplicated. At most one buffered instruction exists.

## Structure
- **Shared `cpu_pkg`:**
  - `XLEN`
  - `RESET_PC` default
  - fetch-state enum {`IDLE`, `REQ`, `HOLD`, `DROP`}
  - PC increment constant 4
- **Sub-module `if_id_reg`:** IF/ID register with load, freeze, and flush (`IF_Valid` clear) inputs. Reused by the top-level pipeline. The FSM, pc_q, buf and drop_addr_q stay in `if_stage`.

## Test plan
- **Reset, steady stream:** release `rst` with `imem_ack`=1 and memory returning addr^0xA5A5_A5A5. Expect `imem_req` high from cycle 1, addresses 0, 4, 8…, `PC`=4, 8, 12… and `IF_Valid`=1 every cycle.
- **Slow memory:** ack 3 cycles after each request. Expect `imem_addr` stable for 3 cycles and `IF_Valid` high 1 cycle in 3.
- **Freeze across a transfer:** ack at addr 0x10 with `Hazard` held 2 cycles. Expect `HOLD`, IF/ID unchanged, then `Instruction`=mem[0x10] with `PC`=0x14 one edge after `Hazard` falls. The next request is 0x14, with no duplicate.
- **Branch while outstanding:** request at 0x20 is pending, `Branch_Taken` with `Branch_Addr`=0x100. Expect `IF_Valid`=0, `imem_addr` held at 0x20 until ack, data dropped, next request 0x100.
- **Branch vs. freeze:** `Branch_Taken`=1, `Hazard`=1 and an ack in the same cycle. Expect `IF_Valid`=0, no `HOLD`, next request 0x100.
- **Wrap and async reset:** pc_q=0xFFFF_FFFC transfer gives `PC`=0 and next address 0. Asserting `rst` mid-wait forces all outputs to their reset values immediately, without a clock edge.
